// File: rtl/dcache_direct_mapped_pkg.sv
// Shared types and constants for the direct-mapped data cache.
// Line geometry is fixed at 16 bytes; index and tag widths follow from the set count.
package dcache_direct_mapped_pkg;

   localparam int unsigned ADDR_W           = 32;
   localparam int unsigned WORD_W           = 32;
   localparam int unsigned LINE_W           = 128;
   localparam int unsigned OFFSET_W         = 4;
   localparam int unsigned DEFAULT_NUM_SETS = 16;

   typedef enum logic [1:0] {
      S_COMPARE   = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2
   } cache_state_e;

   // Index width: one bit per doubling of the set count.
   function automatic int unsigned index_w(input int unsigned num_sets);
      return $clog2(num_sets);
   endfunction

   // Tag width: whatever is left of the address above index and offset.
   function automatic int unsigned tag_w(input int unsigned num_sets);
      return ADDR_W - OFFSET_W - $clog2(num_sets);
   endfunction

endpackage

// File: rtl/dcache_direct_mapped_tag_array.sv
// Valid, dirty and tag storage for the direct-mapped cache.
// Combinational lookup, one synchronous update port, synchronous clear of valid/dirty.
module dcache_tag_array
   import dcache_direct_mapped_pkg::*;
#(
   parameter  int unsigned NUM_SETS = DEFAULT_NUM_SETS,
   localparam int unsigned IDX_W    = index_w(NUM_SETS),
   localparam int unsigned TAG_W    = tag_w(NUM_SETS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] lookup_idx,
   output logic             lookup_valid,
   output logic             lookup_dirty,
   output logic [TAG_W-1:0] lookup_tag,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_valid,
   input  logic             upd_dirty,
   input  logic [TAG_W-1:0] upd_tag
);

   logic [NUM_SETS-1:0] valid_q, valid_d;
   logic [NUM_SETS-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]    tag_q [NUM_SETS];
   logic [TAG_W-1:0]    tag_d [NUM_SETS];

   // Read out the status and tag of the addressed set.
   always_comb begin
      lookup_valid = valid_q[lookup_idx];
      lookup_dirty = dirty_q[lookup_idx];
      lookup_tag   = tag_q[lookup_idx];
   end

   // Apply the single update port to a copy of the current storage.
   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      if (upd_en) begin
         valid_d[upd_idx] = upd_valid;
         dirty_d[upd_idx] = upd_dirty;
         tag_d[upd_idx]   = upd_tag;
      end
   end

   // Valid and dirty bits, cleared by reset.
   always_ff @(posedge clk) begin
      // NOTE: state is written with <= so all flops sample the same pre-edge values.
      if (!reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag storage.
   // NOTE: tags are not reset; they are meaningless while the set's valid bit is low.
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
   end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache.
// Hits complete in the request cycle; misses stall (is_hit=0) through write-back and refill.
// Optional build macro DCACHE_STATS_EN adds hit_count / miss_count outputs.
module dcache_direct_mapped
   import dcache_direct_mapped_pkg::*;
#(
   parameter int unsigned NUM_SETS   = DEFAULT_NUM_SETS,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              is_input_valid,
   input  logic [31:0]       addr,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       din,
   output logic              is_ready,
   output logic              is_output_valid,
   output logic [31:0]       dout,
   output logic              is_hit,
   output logic              mem_req_valid,
   output logic              mem_req_write,
   output logic [31:0]       mem_req_addr,
   output logic [LINE_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [LINE_W-1:0] mem_resp_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int unsigned IDX_W  = index_w(NUM_SETS);
   localparam int unsigned TAG_W  = tag_w(NUM_SETS);
   localparam int unsigned WSEL_W = $clog2(LINE_WORDS);

   cache_state_e      state_q, state_d;
   logic              req_sent_q, req_sent_d;
   logic [LINE_W-1:0] data_q [NUM_SETS];
   logic [LINE_W-1:0] data_d [NUM_SETS];

   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [WSEL_W-1:0] req_word;
   logic              req_valid;
   logic              tag_hit;
   logic              unused_addr_bits;

   logic              lk_valid, lk_dirty;
   logic [TAG_W-1:0]  lk_tag;
   logic              upd_en, upd_valid, upd_dirty;

   assign req_idx          = addr[OFFSET_W +: IDX_W];
   assign req_tag          = addr[ADDR_W-1 -: TAG_W];
   assign req_word         = addr[2 +: WSEL_W];
   assign unused_addr_bits = ^addr[1:0];
   assign req_valid        = is_input_valid && (mem_read || mem_write);
   assign tag_hit          = lk_valid && (lk_tag == req_tag);

   dcache_tag_array #(
      .NUM_SETS(NUM_SETS)
   ) u_tag_array (
      .clk          (clk),
      .reset        (reset),
      .lookup_idx   (req_idx),
      .lookup_valid (lk_valid),
      .lookup_dirty (lk_dirty),
      .lookup_tag   (lk_tag),
      .upd_en       (upd_en),
      .upd_idx      (req_idx),
      .upd_valid    (upd_valid),
      .upd_dirty    (upd_dirty),
      .upd_tag      (req_tag)
   );

   // FSM state register; reset returns to COMPARE.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_COMPARE;
      else        state_q <= state_d;
   end

   // FSM next state: miss picks write-back or refill, memory handshakes advance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_COMPARE: begin
            if (req_valid && !tag_hit) begin
               state_d = (lk_valid && lk_dirty) ? S_WRITEBACK : S_ALLOCATE;
            end
         end
         S_WRITEBACK: begin
            if (mem_req_ready) state_d = S_ALLOCATE;
         end
         S_ALLOCATE: begin
            if (mem_resp_valid) state_d = S_COMPARE;
         end
         default: state_d = S_COMPARE;
      endcase
   end

   // FSM outputs: CPU handshake in COMPARE, memory request in WRITEBACK/ALLOCATE.
   always_comb begin
      is_ready        = 1'b0;
      is_hit          = 1'b0;
      is_output_valid = 1'b0;
      dout            = '0;
      mem_req_valid   = 1'b0;
      mem_req_write   = 1'b0;
      mem_req_addr    = '0;
      mem_req_wdata   = '0;
      case (state_q)
         S_COMPARE: begin
            is_ready = 1'b1;
            if (!req_valid || tag_hit) begin
               is_hit          = 1'b1;
               is_output_valid = 1'b1;
            end
            if (req_valid && tag_hit && mem_read) begin
               dout = data_q[req_idx][req_word*WORD_W +: WORD_W];
            end
         end
         S_WRITEBACK: begin
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_addr  = {lk_tag, req_idx, {OFFSET_W{1'b0}}};
            mem_req_wdata = data_q[req_idx];
         end
         S_ALLOCATE: begin
            if (!req_sent_q) begin
               mem_req_valid = 1'b1;
               mem_req_addr  = {req_tag, req_idx, {OFFSET_W{1'b0}}};
            end
         end
         default: ;
      endcase
   end

   // Line updates: store hit merges a word and marks dirty; refill writes a clean line.
   always_comb begin
      data_d    = data_q;
      upd_en    = 1'b0;
      upd_valid = 1'b0;
      upd_dirty = 1'b0;
      if (state_q == S_COMPARE && req_valid && tag_hit && mem_write) begin
         data_d[req_idx][req_word*WORD_W +: WORD_W] = din;
         upd_en    = 1'b1;
         upd_valid = 1'b1;
         upd_dirty = 1'b1;
      end else if (state_q == S_ALLOCATE && mem_resp_valid) begin
         data_d[req_idx] = mem_resp_rdata;
         upd_en    = 1'b1;
         upd_valid = 1'b1;
      end
   end

   // Refill request is held until accepted, then dropped while waiting for the line.
   always_comb begin
      req_sent_d = 1'b0;
      if (state_q == S_ALLOCATE) begin
         req_sent_d = req_sent_q || mem_req_ready;
         if (mem_resp_valid) req_sent_d = 1'b0;
      end
   end

   // Refill-request handshake flag.
   always_ff @(posedge clk) begin
      if (!reset) req_sent_q <= 1'b0;
      else        req_sent_q <= req_sent_d;
   end

   // Line data storage.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic        refill_q, refill_d;

   // Count first-evaluation hits and miss entries; the re-hit right after a refill is skipped.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      refill_d     = (state_q == S_ALLOCATE) && mem_resp_valid;
      if (state_q == S_COMPARE && req_valid) begin
         if (!tag_hit)       miss_count_d = miss_count_q + 32'd1;
         else if (!refill_q) hit_count_d  = hit_count_q + 32'd1;
      end
   end

   // Statistics counters, zeroed by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
         refill_q     <= 1'b0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         refill_q     <= refill_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule
